// File: rtl/bpred_ctrl.sv
// Branch predictor with a small fully associative target table and a
// mispredict redirect/flush sequencer for the fetch stage.
module bpred_ctrl #(
  parameter int unsigned Psize     = 5,
  parameter int unsigned ENTRIES   = 4,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Psize-1:0] pc_plus,
  output logic [Psize-1:0] predicted_target,
  output logic             take_branch,
  input  logic             resolve_valid,
  input  logic [Psize-1:0] resolve_pc,
  input  logic             resolve_taken,
  input  logic [Psize-1:0] resolve_target,
  input  logic             resolve_pred_taken,
  input  logic [Psize-1:0] resolve_pred_target,
  output logic             redirect_valid,
  output logic [Psize-1:0] redirect_pc,
  output logic             flush,
  output logic             busy,
  output logic [7:0]       mispredict_count
);

  localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [Psize-1:0]   pc_q  [ENTRIES];
  logic [Psize-1:0]   pc_d  [ENTRIES];
  logic [Psize-1:0]   tgt_q [ENTRIES];
  logic [Psize-1:0]   tgt_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [IdxW-1:0]    rr_q, rr_d;

  state_e          state_q, state_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [Psize-1:0] rpc_q, rpc_d;
  logic [7:0]      mcnt_q, mcnt_d;

  logic            lk_hit, rs_hit, fr_found;
  logic [IdxW-1:0] lk_idx, rs_idx, fr_idx, alloc_idx;
  logic            accept, mispredict;

  // Lowest matching index wins for both the fetch lookup and the resolve lookup.
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    rs_hit   = 1'b0;
    rs_idx   = '0;
    fr_found = 1'b0;
    fr_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!lk_hit && valid_q[i] && pc_q[i] == pc_plus) begin
        lk_hit = 1'b1;
        lk_idx = IdxW'(i);
      end
      if (!rs_hit && valid_q[i] && pc_q[i] == resolve_pc) begin
        rs_hit = 1'b1;
        rs_idx = IdxW'(i);
      end
      if (!fr_found && !valid_q[i]) begin
        fr_found = 1'b1;
        fr_idx   = IdxW'(i);
      end
    end
  end

  // Lookup reads registered contents, so a same-cycle update is not visible yet.
  always_comb begin
    take_branch      = lk_hit & ctr_q[lk_idx][1];
    predicted_target = take_branch ? tgt_q[lk_idx] : '0;
  end

  assign accept     = resolve_valid && (state_q == StIdle);
  assign mispredict = (resolve_pred_taken != resolve_taken) ||
                      (resolve_taken && (resolve_pred_target != resolve_target));
  assign alloc_idx  = fr_found ? fr_idx : rr_q;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    rr_d    = rr_q;
    if (accept) begin
      if (rs_hit) begin
        if (resolve_taken) begin
          tgt_d[rs_idx] = resolve_target;
          if (ctr_q[rs_idx] != 2'd3) ctr_d[rs_idx] = ctr_q[rs_idx] + 2'd1;
        end else if (ctr_q[rs_idx] != 2'd0) begin
          ctr_d[rs_idx] = ctr_q[rs_idx] - 2'd1;
        end
      end else if (resolve_taken) begin
        valid_d[alloc_idx] = 1'b1;
        pc_d[alloc_idx]    = resolve_pc;
        tgt_d[alloc_idx]   = resolve_target;
        ctr_d[alloc_idx]   = 2'd2;
        // Round-robin pointer only moves when a live entry is evicted.
        if (!fr_found) rr_d = rr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    rpc_d   = rpc_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      StIdle: begin
        if (accept && mispredict) begin
          state_d = StRedirect;
          rpc_d   = resolve_taken ? resolve_target : resolve_pc;
          if (mcnt_q != 8'hff) mcnt_d = mcnt_q + 8'd1;
        end
      end
      StRedirect: begin
        state_d = StFlush;
        fcnt_d  = '0;
      end
      StFlush: begin
        if (fcnt_q == 3'(FLUSH_CYC - 1)) state_d = StIdle;
        else                              fcnt_d  = fcnt_q + 3'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign redirect_valid   = (state_q == StRedirect);
  assign flush            = (state_q != StIdle);
  assign busy             = (state_q != StIdle);
  assign redirect_pc      = rpc_q;
  assign mispredict_count = mcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd0;
      rr_q    <= '0;
      state_q <= StIdle;
      fcnt_q  <= '0;
      rpc_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      rr_q    <= rr_d;
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rpc_q   <= rpc_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Tag and target storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: tb/tb_bpred_ctrl.sv
// Directed bench for bpred_ctrl: a cycle vector table for the basic allocate,
// redirect and counter behaviour, then sequences for ignore, reset and replacement.
module tb_bpred_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] pc_plus;
  logic [4:0] predicted_target;
  logic       take_branch;
  logic       resolve_valid;
  logic [4:0] resolve_pc;
  logic       resolve_taken;
  logic [4:0] resolve_target;
  logic       resolve_pred_taken;
  logic [4:0] resolve_pred_target;
  logic       redirect_valid;
  logic [4:0] redirect_pc;
  logic       flush;
  logic       busy;
  logic [7:0] mispredict_count;

  int n_pass  = 0;
  int n_total = 0;

  bpred_ctrl #(.Psize(5), .ENTRIES(4), .FLUSH_CYC(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .pc_plus             (pc_plus),
    .predicted_target    (predicted_target),
    .take_branch         (take_branch),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .flush               (flush),
    .busy                (busy),
    .mispredict_count    (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rv;
    logic [4:0] rpc;
    logic       rt;
    logic [4:0] rtgt;
    logic       rpt;
    logic [4:0] rptgt;
    logic [4:0] pcp;
    logic       e_take;
    logic [4:0] e_ptgt;
    logic       e_rv;
    logic [4:0] e_rpc;
    logic       e_fl;
    logic       e_busy;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_resolve();
    resolve_valid       = 1'b0;
    resolve_pc          = '0;
    resolve_taken       = 1'b0;
    resolve_target      = '0;
    resolve_pred_taken  = 1'b0;
    resolve_pred_target = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("wait_idle busy", int'(busy), 0);
  endtask

  task automatic lk(input string name, input logic [4:0] pc,
                    input logic exp_take, input logic [4:0] exp_tgt);
    pc_plus = pc;
    #1;
    chk({name, " take"}, int'(take_branch), int'(exp_take));
    chk({name, " target"}, int'(predicted_target), int'(exp_tgt));
    tick();
  endtask

  // Taken resolve predicted not-taken: always a mispredict; waits out the flush.
  task automatic misp(input logic [4:0] pc, input logic [4:0] tgt);
    resolve_valid       = 1'b1;
    resolve_pc          = pc;
    resolve_taken       = 1'b1;
    resolve_target      = tgt;
    resolve_pred_taken  = 1'b0;
    resolve_pred_target = '0;
    tick();
    clear_resolve();
    wait_idle();
  endtask

  initial begin
    //          rv rpc rt tgt pt ptg pcp | take ptgt rv rpc fl busy cnt
    vecs[0]  = '{0, 0,  0, 0, 0, 0, 28,   0,  0,  0, 0, 0, 0, 0};
    vecs[1]  = '{1, 28, 1, 5, 0, 0, 28,   0,  0,  0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0,  0, 0, 0, 0, 28,   1,  5,  1, 5, 1, 1, 1};
    vecs[3]  = '{0, 0,  0, 0, 0, 0, 28,   1,  5,  0, 5, 1, 1, 1};
    vecs[4]  = '{0, 0,  0, 0, 0, 0, 28,   1,  5,  0, 5, 1, 1, 1};
    vecs[5]  = '{1, 28, 0, 0, 0, 0, 28,   1,  5,  0, 5, 0, 0, 1};
    vecs[6]  = '{1, 28, 0, 0, 0, 0, 28,   0,  0,  0, 5, 0, 0, 1};
    vecs[7]  = '{1, 28, 0, 0, 0, 0, 28,   0,  0,  0, 5, 0, 0, 1};
    vecs[8]  = '{1, 28, 1, 5, 1, 5, 28,   0,  0,  0, 5, 0, 0, 1};
    vecs[9]  = '{1, 28, 1, 5, 1, 5, 28,   0,  0,  0, 5, 0, 0, 1};
    vecs[10] = '{0, 0,  0, 0, 0, 0, 28,   1,  5,  0, 5, 0, 0, 1};
    vecs[11] = '{0, 0,  0, 0, 0, 0, 3,    0,  0,  0, 5, 0, 0, 1};

    reset = 1'b1;
    pc_plus = '0;
    clear_resolve();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Allocate, redirect/flush, counter walk down to 0 and back up.
    for (int i = 0; i < 12; i++) begin
      resolve_valid       = vecs[i].rv;
      resolve_pc          = vecs[i].rpc;
      resolve_taken       = vecs[i].rt;
      resolve_target      = vecs[i].rtgt;
      resolve_pred_taken  = vecs[i].rpt;
      resolve_pred_target = vecs[i].rptgt;
      pc_plus             = vecs[i].pcp;
      #1;
      chk($sformatf("vec%0d take_branch", i), int'(take_branch), int'(vecs[i].e_take));
      chk($sformatf("vec%0d predicted_target", i), int'(predicted_target),
          int'(vecs[i].e_ptgt));
      chk($sformatf("vec%0d redirect_valid", i), int'(redirect_valid), int'(vecs[i].e_rv));
      chk($sformatf("vec%0d redirect_pc", i), int'(redirect_pc), int'(vecs[i].e_rpc));
      chk($sformatf("vec%0d flush", i), int'(flush), int'(vecs[i].e_fl));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d mispredict_count", i), int'(mispredict_count),
          int'(vecs[i].e_cnt));
      tick();
    end
    clear_resolve();

    // Not-taken mispredict redirects to resolve_pc; a resolve during FLUSH is ignored.
    resolve_valid       = 1'b1;
    resolve_pc          = 5'd28;
    resolve_taken       = 1'b0;
    resolve_pred_taken  = 1'b1;
    resolve_pred_target = 5'd5;
    pc_plus             = 5'd28;
    tick();
    clear_resolve();
    chk("nt redirect_valid", int'(redirect_valid), 1);
    chk("nt redirect_pc", int'(redirect_pc), 28);
    chk("nt count", int'(mispredict_count), 2);
    tick();
    resolve_valid       = 1'b1;
    resolve_pc          = 5'd10;
    resolve_taken       = 1'b1;
    resolve_target      = 5'd7;
    resolve_pred_taken  = 1'b0;
    #1;
    chk("in flush flush", int'(flush), 1);
    chk("in flush redirect_valid", int'(redirect_valid), 0);
    tick();
    clear_resolve();
    wait_idle();
    chk("ignored count", int'(mispredict_count), 2);
    chk("redirect_pc held", int'(redirect_pc), 28);
    lk("ignored pc10", 5'd10, 1'b0, 5'd0);
    lk("pc28 ctr1", 5'd28, 1'b0, 5'd0);

    // Reset in the middle of a flush.
    resolve_valid      = 1'b1;
    resolve_pc         = 5'd9;
    resolve_taken      = 1'b1;
    resolve_target     = 5'd20;
    resolve_pred_taken = 1'b0;
    tick();
    clear_resolve();
    tick();
    chk("pre-reset flush", int'(flush), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset flush", int'(flush), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset redirect_valid", int'(redirect_valid), 0);
    chk("reset redirect_pc", int'(redirect_pc), 0);
    chk("reset count", int'(mispredict_count), 0);
    lk("reset pc28", 5'd28, 1'b0, 5'd0);
    lk("reset pc9", 5'd9, 1'b0, 5'd0);

    // Fill four entries, then two round-robin replacements: entry 0, then entry 1.
    for (int i = 1; i <= 5; i++) misp(5'(i), 5'(10 + i));
    lk("rr pc1 evicted", 5'd1, 1'b0, 5'd0);
    lk("rr pc2", 5'd2, 1'b1, 5'd12);
    lk("rr pc3", 5'd3, 1'b1, 5'd13);
    lk("rr pc4", 5'd4, 1'b1, 5'd14);
    lk("rr pc5", 5'd5, 1'b1, 5'd15);
    chk("rr count", int'(mispredict_count), 5);
    misp(5'd6, 5'd16);
    lk("rr pc2 evicted", 5'd2, 1'b0, 5'd0);
    lk("rr pc6", 5'd6, 1'b1, 5'd16);
    lk("rr pc5 kept", 5'd5, 1'b1, 5'd15);

    // Counter saturation at 255.
    for (int i = 0; i < 255; i++) misp(5'd7, 5'd17);
    chk("sat count", int'(mispredict_count), 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
